// File: rtl/vga_sync_gen.sv
// Sync/blanking generator: samples the horizontal count, tracks the line, registers all timing outputs.
// Optional frame counter is built only when VGA_SYNC_FRAMECOUNT_EN is defined.
module vga_sync_gen #(
   parameter int   H_VISIBLE = 200,
   parameter int   H_FP      = 10,
   parameter int   H_SYNC    = 32,
   parameter int   H_BP      = 22,
   parameter int   V_VISIBLE = 600,
   parameter int   V_FP      = 1,
   parameter int   V_SYNC    = 4,
   parameter int   V_BP      = 23,
   parameter logic HSYNC_POL = 1'b1,
   parameter logic VSYNC_POL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] hcount,
   output logic       hsync,
   output logic       vsync,
   output logic       hblank,
   output logic       vblank,
   output logic       de,
   output logic [7:0] pix_x,
   output logic [9:0] pix_y,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // One extra bit so totals of exactly 512 / 1024 still fit the comparisons.
   localparam logic [9:0]  H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0]  H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]  H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

   logic [9:0]  h_ext;
   logic [10:0] line_ext;
   logic [9:0]  line_reg, line_next;
   logic        wrap;

   logic       hsync_reg, hsync_next;
   logic       vsync_reg, vsync_next;
   logic       hblank_reg, hblank_next;
   logic       vblank_reg, vblank_next;
   logic       de_reg, de_next;
   logic [7:0] pix_x_reg, pix_x_next;
   logic [9:0] pix_y_reg, pix_y_next;
   logic       line_start_reg, line_start_next;
   logic       frame_start_reg, frame_start_next;

   assign h_ext    = {1'b0, hcount};
   assign line_ext = {1'b0, line_reg};

   always_comb begin
      hblank_next      = (h_ext >= H_VIS_END);
      vblank_next      = (line_ext >= V_VIS_END);
      de_next          = !hblank_next && !vblank_next;
      hsync_next       = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HSYNC_POL : !HSYNC_POL;
      vsync_next       = ((line_ext >= V_SYNC_BEG) && (line_ext < V_SYNC_END)) ? VSYNC_POL : !VSYNC_POL;
      pix_x_next       = de_next ? hcount[7:0] : 8'd0;
      pix_y_next       = de_next ? line_reg : 10'd0;
      line_start_next  = (hcount == 9'd0);
      frame_start_next = (hcount == 9'd0) && (line_reg == 10'd0);

      // Only the last count of a line advances; out-of-range or skipped counts leave line alone.
      wrap      = (h_ext == H_LAST) && (line_ext == V_LAST);
      line_next = line_reg;
      if (h_ext == H_LAST)
         line_next = wrap ? 10'd0 : line_reg + 10'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_reg        <= 10'd0;
         hsync_reg       <= !HSYNC_POL;
         vsync_reg       <= !VSYNC_POL;
         hblank_reg      <= 1'b1;
         vblank_reg      <= 1'b0;
         de_reg          <= 1'b0;
         pix_x_reg       <= 8'd0;
         pix_y_reg       <= 10'd0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         line_reg        <= line_next;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         hblank_reg      <= hblank_next;
         vblank_reg      <= vblank_next;
         de_reg          <= de_next;
         pix_x_reg       <= pix_x_next;
         pix_y_reg       <= pix_y_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

`ifdef VGA_SYNC_FRAMECOUNT_EN
   logic [7:0] frame_count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         frame_count_reg <= 8'd0;
      else if (wrap)
         frame_count_reg <= frame_count_reg + 8'd1;
   end

   assign frame_count = frame_count_reg;
`else
   assign frame_count = 8'd0;
`endif

   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign hblank      = hblank_reg;
   assign vblank      = vblank_reg;
   assign de          = de_reg;
   assign pix_x       = pix_x_reg;
   assign pix_y       = pix_y_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen at default 800x600 timing; lines are stepped quickly by repeating h=263.
module tb_vga_sync_gen;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic [8:0] hcount = 9'd5;
   logic       hsync, vsync, hblank, vblank, de, line_start, frame_start;
   logic [7:0] pix_x, frame_count;
   logic [9:0] pix_y;

   int compared   = 0;
   int mismatched = 0;
   int exp_line   = 0;
   int exp_fc     = 0;
   int fs_seen    = 0;
   int vs_lines   = 0;
   int fc_on;

   vga_sync_gen dut (
      .clk         (clk),
      .rst         (rst),
      .hcount      (hcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .hblank      (hblank),
      .vblank      (vblank),
      .de          (de),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_hsync"},  32'(hsync),       32'd0);
      check({tag, "_vsync"},  32'(vsync),       32'd0);
      check({tag, "_hblank"}, 32'(hblank),      32'd1);
      check({tag, "_vblank"}, 32'(vblank),      32'd0);
      check({tag, "_de"},     32'(de),          32'd0);
      check({tag, "_pix_x"},  32'(pix_x),       32'd0);
      check({tag, "_pix_y"},  32'(pix_y),       32'd0);
      check({tag, "_lstart"}, 32'(line_start),  32'd0);
      check({tag, "_fstart"}, 32'(frame_start), 32'd0);
      check({tag, "_fcount"}, 32'(frame_count), 32'd0);
      $display("reset check %s at t=%0t", tag, $time);
   endtask

   // Drive one count, clock it, and compare every output against the timing rules.
   task automatic step(input int h);
      int e_hs, e_vs, e_hb, e_vb, e_de, e_px, e_py, e_ls, e_fs;
      e_hs = (h >= 210 && h < 242) ? 1 : 0;
      e_vs = (exp_line >= 601 && exp_line < 605) ? 1 : 0;
      e_hb = (h >= 200) ? 1 : 0;
      e_vb = (exp_line >= 600) ? 1 : 0;
      e_de = (e_hb == 0 && e_vb == 0) ? 1 : 0;
      e_px = e_de ? h : 0;
      e_py = e_de ? exp_line : 0;
      e_ls = (h == 0) ? 1 : 0;
      e_fs = (h == 0 && exp_line == 0) ? 1 : 0;
      hcount = 9'(h);
      @(posedge clk);
      #1;
      check("hsync",       32'(hsync),       32'(e_hs));
      check("vsync",       32'(vsync),       32'(e_vs));
      check("hblank",      32'(hblank),      32'(e_hb));
      check("vblank",      32'(vblank),      32'(e_vb));
      check("de",          32'(de),          32'(e_de));
      check("pix_x",       32'(pix_x),       32'(e_px));
      check("pix_y",       32'(pix_y),       32'(e_py));
      check("line_start",  32'(line_start),  32'(e_ls));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      if (h == 263) begin
         if (exp_line == 627) begin
            exp_line = 0;
            exp_fc   = (exp_fc + fc_on) % 256;
         end else begin
            exp_line = exp_line + 1;
         end
      end
      check("frame_count", 32'(frame_count), 32'(exp_fc));
      fs_seen += 32'(frame_start);
      $display("step h=%0d line=%0d hs=%b vs=%b hb=%b vb=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               h, exp_line, hsync, vsync, hblank, vblank, de, pix_x, pix_y, line_start, frame_start,
               frame_count);
   endtask

   initial begin
`ifdef VGA_SYNC_FRAMECOUNT_EN
      fc_on = 1;
`else
      fc_on = 0;
`endif
      // Reset asserted with h=5 and no clock edge yet.
      #1 rst = 1'b0;
      #1 check_reset("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int h = 0; h < 264; h++)
         step(h);

      step(0);
      check("adv_pix_y",  32'(pix_y),      32'd1);
      check("adv_lstart", 32'(line_start), 32'd1);

      while (exp_line < 599)
         step(263);
      step(0);
      check("l599_y", 32'(pix_y), 32'd599);
      step(263);
      check("l599_end_vblank", 32'(vblank), 32'd0);
      step(0);
      check("l600_vblank", 32'(vblank), 32'd1);
      check("l600_de",     32'(de),     32'd0);
      step(100);
      check("l600_de_mid", 32'(de),     32'd0);

      // Finish frame 0, then one complete frame counting sync lines and frame pulses.
      fs_seen = 0;
      while (exp_line != 0) begin
         step(0);
         step(263);
      end
      check("fc_frame0", 32'(frame_count), 32'(fc_on));
      check("fs_tail",   32'(fs_seen),     32'd0);
      fs_seen  = 0;
      vs_lines = 0;
      for (int l = 0; l < 628; l++) begin
         step(0);
         vs_lines += 32'(vsync);
         step(263);
      end
      check("fs_per_frame", 32'(fs_seen),     32'd1);
      check("vsync_lines",  32'(vs_lines),    32'd4);
      check("fc_frame1",    32'(frame_count), 32'(2 * fc_on));

      // Out-of-range and mid-line restart on line 10.
      repeat (10) step(263);
      step(300);
      check("oor_hblank", 32'(hblank), 32'd1);
      check("oor_hsync",  32'(hsync),  32'd0);
      step(0);
      check("oor_no_adv", 32'(pix_y),  32'd10);
      step(150);
      check("jump_x",     32'(pix_x),  32'd150);
      step(0);
      check("jump_y",      32'(pix_y),      32'd10);
      check("jump_lstart", 32'(line_start), 32'd1);

      // Asynchronous reset between edges on line 400.
      while (exp_line < 400)
         step(263);
      step(50);
      check("pre_reset_y", 32'(pix_y), 32'd400);
      #2 rst = 1'b0;
      #1 check_reset("mid");
      exp_line = 0;
      exp_fc   = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(50);
      check("post_reset_y", 32'(pix_y), 32'd0);
      check("post_reset_x", 32'(pix_x), 32'd50);
      step(263);
      step(0);
      check("post_reset_adv", 32'(pix_y), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      mismatched++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "watchdog expired");
   end

endmodule
